load_store_unit: RTL

//  Memory stage after the ALU. Takes ALUResult as the effective address plus store data and funct3.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/lsu_align.sv | 58 +++++
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage: funct3 load/store widths, LSU error codes
// and the load/store unit state type.
package riscv_pkg;

   localparam logic [2:0] FUNCT3_B  = 3'b000;
   localparam logic [2:0] FUNCT3_H  = 3'b001;
   localparam logic [2:0] FUNCT3_W  = 3'b010;
   localparam logic [2:0] FUNCT3_BU = 3'b100;
   localparam logic [2:0] FUNCT3_HU = 3'b101;

   localparam logic [1:0] LSU_ERR_NONE     = 2'b00;
   localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
   localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store byte enables and lane-replicated
// write data, alignment/legality decode, and load data shift plus sign/zero extension.
module lsu_align
   import riscv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       funct3_i,
   input  logic [1:0]       byte_off_i,
   input  logic             is_read_i,
   input  logic             is_write_i,
   input  logic [WIDTH-1:0] store_data_i,
   input  logic [WIDTH-1:0] rdata_i,
   output logic [3:0]       be_o,
   output logic [WIDTH-1:0] wdata_o,
   output logic             misalign_o,
   output logic             illegal_o,
   output logic [WIDTH-1:0] load_data_o
);

   logic [WIDTH-1:0] shifted;

   always_comb begin
      be_o        = 4'b0000;
      wdata_o     = '0;
      misalign_o  = 1'b0;
      illegal_o   = 1'b0;
      load_data_o = '0;
      shifted     = rdata_i >> {byte_off_i, 3'b000};
      case (funct3_i)
         FUNCT3_B, FUNCT3_BU: begin
            be_o        = 4'b0001 << byte_off_i;
            wdata_o     = {4{store_data_i[7:0]}};
            load_data_o = (funct3_i == FUNCT3_B) ? {{(WIDTH-8){shifted[7]}}, shifted[7:0]}
                                                 : {{(WIDTH-8){1'b0}}, shifted[7:0]};
         end
         FUNCT3_H, FUNCT3_HU: begin
            be_o        = 4'b0011 << byte_off_i;
            wdata_o     = {2{store_data_i[15:0]}};
            misalign_o  = byte_off_i[0];
            load_data_o = (funct3_i == FUNCT3_H) ? {{(WIDTH-16){shifted[15]}}, shifted[15:0]}
                                                 : {{(WIDTH-16){1'b0}}, shifted[15:0]};
         end
         FUNCT3_W: begin
            be_o        = 4'b1111;
            wdata_o     = store_data_i;
            misalign_o  = (byte_off_i != 2'b00);
            load_data_o = shifted;
         end
         default: illegal_o = 1'b1;
      endcase
      // Unsigned stores do not exist, and a simultaneous read+write is meaningless.
      if ((is_write_i && funct3_i[2]) || (is_read_i && is_write_i)) begin
         illegal_o = 1'b1;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: runs one load or store per instruction over a req/gnt/rvalid word bus,
// holds the pipeline until it completes, and reports misaligned/illegal/timeout errors.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lsu_valid,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] store_data,
   output logic             stall,
   output logic             lsu_done,
   output logic [WIDTH-1:0] load_data,
   output logic             lsu_err,
   output logic [1:0]       lsu_err_code,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [3:0]       mem_be,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [WIDTH-1:0] mem_rdata,
   output lsu_state_t       dbg_state
);

   localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   lsu_state_t       state_q, state_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] ld_q, ld_d;
   logic             we_q, we_d;
   logic [3:0]       be_q, be_d;
   logic [2:0]       f3_q, f3_d;
   logic             err_q, err_d;
   logic [1:0]       code_q, code_d;
   logic [15:0]      cnt_q, cnt_d;

   logic             accept;
   logic             timeout_hit;
   logic [2:0]       al_f3;
   logic [1:0]       al_off;
   logic             al_rd, al_wr;
   logic [3:0]       al_be;
   logic [WIDTH-1:0] al_wdata, al_ld;
   logic             al_mis, al_ill;

   assign accept      = lsu_valid && (mem_read || mem_write);
   assign timeout_hit = TO_EN && (cnt_q >= TO_LIMIT);

   // The aligner decodes live inputs while idle and the latched access afterwards.
   always_comb begin
      if (state_q == LSU_IDLE) begin
         al_f3  = funct3;
         al_off = addr[1:0];
         al_rd  = mem_read;
         al_wr  = mem_write;
      end else begin
         al_f3  = f3_q;
         al_off = addr_q[1:0];
         al_rd  = ~we_q;
         al_wr  = we_q;
      end
   end

   lsu_align #(.WIDTH(WIDTH)) u_align (
      .funct3_i     (al_f3),
      .byte_off_i   (al_off),
      .is_read_i    (al_rd),
      .is_write_i   (al_wr),
      .store_data_i (store_data),
      .rdata_i      (mem_rdata),
      .be_o         (al_be),
      .wdata_o      (al_wdata),
      .misalign_o   (al_mis),
      .illegal_o    (al_ill),
      .load_data_o  (al_ld)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LSU_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE: if (accept) state_d = (al_ill || al_mis) ? LSU_DONE : LSU_REQ;
         LSU_REQ: begin
            if (mem_gnt)          state_d = LSU_WAIT;
            else if (timeout_hit) state_d = LSU_DONE;
         end
         LSU_WAIT: begin
            if (mem_rvalid)       state_d = LSU_DONE;
            else if (timeout_hit) state_d = LSU_DONE;
         end
         LSU_DONE: state_d = LSU_IDLE;
         default:  state_d = LSU_IDLE;
      endcase
   end

   // Access latch, timeout counter and completion result.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      be_d    = be_q;
      f3_d    = f3_q;
      cnt_d   = cnt_q;
      ld_d    = ld_q;
      err_d   = err_q;
      code_d  = code_q;
      case (state_q)
         LSU_IDLE: begin
            if (accept) begin
               addr_d  = addr;
               we_d    = mem_write;
               be_d    = al_be;
               wdata_d = al_wdata;
               f3_d    = funct3;
               cnt_d   = '0;
               ld_d    = '0;
               err_d   = al_ill || al_mis;
               code_d  = al_ill ? LSU_ERR_ILLEGAL : (al_mis ? LSU_ERR_MISALIGN : LSU_ERR_NONE);
            end
         end
         LSU_REQ: begin
            cnt_d = cnt_q + 16'd1;
            if (!mem_gnt && timeout_hit) begin
               err_d  = 1'b1;
               code_d = LSU_ERR_TIMEOUT;
               ld_d   = '0;
            end
         end
         LSU_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            if (mem_rvalid) begin
               ld_d = we_q ? '0 : al_ld;
            end else if (timeout_hit) begin
               err_d  = 1'b1;
               code_d = LSU_ERR_TIMEOUT;
               ld_d   = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         be_q    <= 4'b0000;
         f3_q    <= 3'b000;
         cnt_q   <= '0;
         ld_q    <= '0;
         err_q   <= 1'b0;
         code_q  <= LSU_ERR_NONE;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         be_q    <= be_d;
         f3_q    <= f3_d;
         cnt_q   <= cnt_d;
         ld_q    <= ld_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   // Valid/ready: mem_req stays high with stable addr/we/be/wdata until the cycle mem_gnt is
   // seen; the access then completes on the first mem_rvalid after the grant cycle.
   always_comb begin
      stall        = accept && (state_q != LSU_DONE);
      mem_req      = (state_q == LSU_REQ);
      mem_we       = (state_q == LSU_REQ) && we_q;
      mem_addr     = {addr_q[WIDTH-1:2], 2'b00};
      mem_be       = be_q;
      mem_wdata    = wdata_q;
      lsu_done     = (state_q == LSU_DONE);
      load_data    = lsu_done ? ld_q : '0;
      lsu_err      = lsu_done && err_q;
      lsu_err_code = lsu_done ? code_q : LSU_ERR_NONE;
      dbg_state    = state_q;
   end

endmodule
